string_send: RTL and testbench

- UART string transmitter; the transmit-side counterpart of the receive-side string capture block.
- On a `send` pulse it latches a packed byte buffer and length, then emits `start_signal` followed by `str_len` payload bytes, byte 0 first, through a byte-wide UART TX handshake.
- Sits between control logic (status and echo reporting to the host) and the `uart_tx` core.
- Byte indexing matches the receive side: a loopback through the receiver yields the identical `str_buf`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/string_send.sv | 128 ++++++++++++
 tb/tb_string_send.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default framing character and the
// state encoding of the string transmitter FSM.
package uart_pkg;

    localparam int byte_w = 8;
    localparam logic [byte_w-1:0] default_start = 8'h2E;  // "."

    localparam logic [2:0] st_idle    = 3'd0;
    localparam logic [2:0] st_issue   = 3'd1;
    localparam logic [2:0] st_wait_hi = 3'd2;
    localparam logic [2:0] st_wait_lo = 3'd3;
    localparam logic [2:0] st_done    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = st_idle,
        ISSUE   = st_issue,
        WAIT_HI = st_wait_hi,
        WAIT_LO = st_wait_lo,
        DONE    = st_done
    } state_t;

endpackage

// File: rtl/string_send.sv
// UART string transmitter: on a send pulse, latches a packed byte buffer and
// emits start_signal followed by the payload (byte 0 first) to uart_tx.
//
// Handshake: tx_en is a one-cycle pulse issued only while tx_busy is low; the
// byte is considered accepted once tx_busy rises, and complete once it falls.
module string_send
    import uart_pkg::*;
#(
    parameter int                 byte_num     = 8,
    parameter logic [byte_w-1:0]  start_signal = default_start,
    parameter int                 len_width    = $clog2(byte_num + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [byte_num*8-1:0]    str_buf,
    input  logic [len_width-1:0]     str_len,
    input  logic                     send,
    output logic [byte_w-1:0]        tx_data,
    output logic                     tx_en,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state
);

    localparam logic [len_width-1:0] max_len = len_width'(byte_num);
    localparam logic [len_width-1:0] one_len = len_width'(1);

    state_t                  cur, nxt;
    logic [byte_num*8-1:0]   sbuf, sbuf_n;
    logic [len_width-1:0]    len, len_n;
    logic [len_width-1:0]    idx, idx_n;
    logic                    hdr, hdr_n;
    logic [byte_w-1:0]       tx_data_n;
    logic                    tx_en_n, busy_n, done_n;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= IDLE;
            sbuf    <= '0;
            len     <= '0;
            idx     <= '0;
            hdr     <= 1'b0;
            tx_data <= '0;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cur     <= nxt;
            sbuf    <= sbuf_n;
            len     <= len_n;
            idx     <= idx_n;
            hdr     <= hdr_n;
            tx_data <= tx_data_n;
            tx_en   <= tx_en_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        nxt       = cur;
        sbuf_n    = sbuf;
        len_n     = len;
        idx_n     = idx;
        hdr_n     = hdr;
        tx_data_n = tx_data;
        tx_en_n   = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;

        case (cur)
            IDLE: begin
                if (send) begin
                    sbuf_n = str_buf;
                    len_n  = (str_len > max_len) ? max_len : str_len;
                    idx_n  = '0;
                    hdr_n  = 1'b1;
                    busy_n = 1'b1;
                    nxt    = ISSUE;
                end
            end

            ISSUE: begin
                if (!tx_busy) begin
                    tx_data_n = hdr ? start_signal : sbuf[idx*byte_w +: byte_w];
                    tx_en_n   = 1'b1;
                    nxt       = WAIT_HI;
                end
            end

            WAIT_HI: begin
                if (tx_busy) begin
                    nxt = WAIT_LO;
                end
            end

            WAIT_LO: begin
                // idx only advances when another payload byte follows, so it
                // stays within 0..byte_num-1.
                if (!tx_busy) begin
                    if (hdr) begin
                        hdr_n = 1'b0;
                        nxt   = (len == '0) ? DONE : ISSUE;
                    end else if ((idx + one_len) == len) begin
                        nxt = DONE;
                    end else begin
                        idx_n = idx + one_len;
                        nxt   = ISSUE;
                    end
                end
            end

            DONE: begin
                done_n = 1'b1;
                busy_n = 1'b0;
                nxt    = IDLE;
            end

            default: begin
                nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_string_send.sv
// Directed bench for string_send with a behavioural uart_tx busy model and a
// behavioural receive-side reassembly for the loopback check.
module tb_string_send;
    import uart_pkg::*;

    localparam int byte_num  = 4;
    localparam int len_width = $clog2(byte_num + 1);
    localparam int tx_cycles = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [byte_num*8-1:0]  str_buf = '0;
    logic [len_width-1:0]   str_len = '0;
    logic                   send = 1'b0;
    logic [7:0]             tx_data;
    logic                   tx_en;
    logic                   tx_busy;
    logic                   busy;
    logic                   done;
    logic [2:0]             state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_cnt;
    int         busy_bad;
    int         tx_cnt = 0;

    string_send #(
        .byte_num    (byte_num),
        .start_signal(8'h2E),
        .len_width   (len_width)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .str_buf(str_buf),
        .str_len(str_len),
        .send   (send),
        .tx_data(tx_data),
        .tx_en  (tx_en),
        .tx_busy(tx_busy),
        .busy   (busy),
        .done   (done),
        .state  (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // uart_tx model: busy for tx_cycles after accepting a byte; ignores rst so
    // an accepted byte keeps shifting out after an abort.
    always @(posedge clk) begin
        if (tx_en && tx_cnt == 0) tx_cnt <= tx_cycles;
        else if (tx_cnt != 0)     tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag);
        logic [31:0] o;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), o, {24'h0, exp_q[i]});
        end
    endtask

    // Pulses send, then records tx bytes, done pulses and busy drops until
    // 15 cycles after done (bounded). Optionally injects a second send and a
    // buffer change mid-transfer.
    task automatic run_xfer(input bit inject);
        bit seen_done;
        int post;
        got_q.delete();
        done_cnt  = 0;
        busy_bad  = 0;
        seen_done = 0;
        post      = 0;
        @(negedge clk);
        send = 1'b1;
        for (int cyc = 0; cyc < 2000 && post < 15; cyc++) begin
            @(negedge clk);
            send = 1'b0;
            if (inject && cyc == 25) begin
                send    = 1'b1;
                str_buf = 32'hDEADBEEF;
                str_len = 3'd1;
            end
            if (tx_en) got_q.push_back(tx_data);
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
            end else if (!seen_done && !busy) begin
                busy_bad++;
            end
            if (seen_done) post++;
        end
        send = 1'b0;
        check("done_seen", {31'h0, seen_done}, 32'd1);
    endtask

    initial begin
        logic [31:0] rx_buf;
        int          en_seen;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_en", {31'h0, tx_en}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_state", {29'h0, state}, 32'd0);
        rst = 1'b0;

        // full 4-byte string
        str_buf = 32'h44434241;
        str_len = 3'd4;
        exp_q   = '{8'h2E, 8'h41, 8'h42, 8'h43, 8'h44};
        run_xfer(1'b0);
        check_seq("full");
        check("full_done_cnt", done_cnt, 32'd1);
        check("full_busy_hold", busy_bad, 32'd0);
        check("full_busy_idle", {31'h0, busy}, 32'd0);

        // empty payload: header only
        str_len = 3'd0;
        exp_q   = '{8'h2E};
        run_xfer(1'b0);
        check_seq("empty");
        check("empty_done_cnt", done_cnt, 32'd1);
        check("empty_busy_idle", {31'h0, busy}, 32'd0);

        // over-length request clamps to byte_num
        str_buf = 32'h44434241;
        str_len = 3'd7;
        exp_q   = '{8'h2E, 8'h41, 8'h42, 8'h43, 8'h44};
        run_xfer(1'b0);
        check_seq("clamp");
        check("clamp_done_cnt", done_cnt, 32'd1);

        // second send and buffer change mid-transfer are ignored
        str_buf = 32'h44434241;
        str_len = 3'd4;
        run_xfer(1'b1);
        check_seq("ignore");
        check("ignore_done_cnt", done_cnt, 32'd1);
        check("ignore_busy_hold", busy_bad, 32'd0);

        // reset after the 3rd tx_en aborts without a done pulse
        str_buf = 32'h44434241;
        str_len = 3'd4;
        en_seen = 0;
        @(negedge clk);
        send = 1'b1;
        for (int cyc = 0; cyc < 500 && en_seen < 3; cyc++) begin
            @(negedge clk);
            send = 1'b0;
            if (tx_en) en_seen++;
        end
        check("abort_en_seen", en_seen, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx_en", {31'h0, tx_en}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_state", {29'h0, state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);

        // restart after abort begins with the header again
        run_xfer(1'b0);
        check_seq("restart");
        check("restart_done_cnt", done_cnt, 32'd1);

        // loopback: receive side rebuilds str_buf from the byte stream
        str_buf = 32'h34333231;
        str_len = 3'd4;
        run_xfer(1'b0);
        rx_buf = '0;
        for (int i = 1; i < got_q.size() && i <= byte_num; i++) begin
            rx_buf[(i-1)*8 +: 8] = got_q[i];
        end
        check("loop_header", (got_q.size() > 0) ? {24'h0, got_q[0]} : 32'hFFFF_FFFF, 32'h2E);
        check("loop_len", got_q.size(), 32'd5);
        check("loop_buf", rx_buf, 32'h34333231);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
